// File: rtl/pipe_hazard_ctrl.sv
// Hazard/pipeline-control unit for the 5-stage MIPS core: stalls, flushes,
// forwarding selects and the multi-cycle divide sequencer.
module pipe_hazard_ctrl #(
    parameter int unsigned DIV_CYCLES = 32,
    parameter int unsigned CW         = $clog2(DIV_CYCLES)
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [4:0] rsD,
    input  logic [4:0] rtD,
    input  logic [4:0] rsE,
    input  logic [4:0] rtE,
    input  logic [4:0] writeregE,
    input  logic [4:0] writeregM,
    input  logic [4:0] writeregW,
    input  logic       regwriteE,
    input  logic       regwriteM,
    input  logic       regwriteW,
    input  logic       memtoregE,
    input  logic       memtoregM,
    input  logic       branchD,
    input  logic       pcsrcD,
    input  logic       jumpD,
    input  logic       divstartE,
    output logic       stallF,
    output logic       stallD,
    output logic       stallE,
    output logic       flushD,
    output logic       flushE,
    output logic       forwardAD,
    output logic       forwardBD,
    output logic [1:0] forwardAE,
    output logic [1:0] forwardBE,
    output logic       div_busy,
    output logic       div_ready
);

    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

    state_t        state_q, state_d;
    logic [CW-1:0] cnt_q, cnt_d;

    logic lwstall, branchstall, divstall, front_stall;

    // Register 0 is hardwired, so it never creates a dependency.
    function automatic logic rmatch(input logic [4:0] a, input logic [4:0] b);
        return (a != 5'd0) && (a == b);
    endfunction

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

    // RUN leaves when the counter is about to reach 0, giving DIV_CYCLES-2 RUN
    // cycles; with DIV_CYCLES==2 there are none, so IDLE goes straight to DONE.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        unique case (state_q)
            IDLE: begin
                if (divstartE) begin
                    cnt_d   = CW'(DIV_CYCLES - 2);
                    state_d = (DIV_CYCLES == 2) ? DONE : RUN;
                end
            end
            RUN: begin
                cnt_d = cnt_q - 1'b1;
                if (cnt_q <= CW'(1)) state_d = DONE;
            end
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        divstall    = ((state_q == IDLE) && divstartE) || (state_q == RUN);
        lwstall     = memtoregE && (rmatch(writeregE, rsD) || rmatch(writeregE, rtD));
        branchstall = branchD &&
                      ((regwriteE && (rmatch(writeregE, rsD) || rmatch(writeregE, rtD))) ||
                       (memtoregM && (rmatch(writeregM, rsD) || rmatch(writeregM, rtD))));
        front_stall = lwstall || branchstall || divstall;

        stallF    = front_stall;
        stallD    = front_stall;
        stallE    = divstall;
        flushE    = (lwstall || branchstall) && !divstall;
        flushD    = (pcsrcD || jumpD) && !front_stall;
        div_busy  = divstall;
        div_ready = (state_q == DONE);

        forwardAD = regwriteM && rmatch(writeregM, rsD);
        forwardBD = regwriteM && rmatch(writeregM, rtD);

        forwardAE = 2'b00;
        if (regwriteM && rmatch(writeregM, rsE))      forwardAE = 2'b10;
        else if (regwriteW && rmatch(writeregW, rsE)) forwardAE = 2'b01;

        forwardBE = 2'b00;
        if (regwriteM && rmatch(writeregM, rtE))      forwardBE = 2'b10;
        else if (regwriteW && rmatch(writeregW, rtE)) forwardBE = 2'b01;
    end

endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// Self-checking bench for pipe_hazard_ctrl: table-driven single-cycle vectors
// plus hand-written divide sequences, checked through an expected-value queue.
module tb_pipe_hazard_ctrl;

    localparam int unsigned DIVC = 4;

    // Control bit positions for mk(): {rst,regwriteE,regwriteM,regwriteW,memtoregE,memtoregM,branchD,pcsrcD,jumpD,divstartE}
    localparam logic [9:0] RST = 10'b1000000000;
    localparam logic [9:0] RWE = 10'b0100000000;
    localparam logic [9:0] RWM = 10'b0010000000;
    localparam logic [9:0] RWW = 10'b0001000000;
    localparam logic [9:0] MTE = 10'b0000100000;
    localparam logic [9:0] MTM = 10'b0000010000;
    localparam logic [9:0] BR  = 10'b0000001000;
    localparam logic [9:0] PC  = 10'b0000000100;
    localparam logic [9:0] JMP = 10'b0000000010;
    localparam logic [9:0] DIV = 10'b0000000001;

    // Expected bundle: {stallF,stallD,stallE,flushD,flushE}_{fAD,fBD}_{fAE}_{fBE}_{busy,ready}
    localparam logic [12:0] E_ZERO = 13'b00000_00_00_00_00;
    localparam logic [12:0] E_HAZ  = 13'b11001_00_00_00_00;
    localparam logic [12:0] E_DIV  = 13'b11100_00_00_00_10;
    localparam logic [12:0] E_DONE = 13'b00000_00_00_00_01;
    localparam logic [12:0] E_FD   = 13'b00010_00_00_00_00;

    typedef struct packed {
        logic [4:0] rsD, rtD, rsE, rtE, wE, wM, wW;
        logic [9:0] ctl;
    } in_t;

    typedef struct {
        string       name;
        in_t         in;
        logic [12:0] exp;
    } vec_t;

    typedef struct {
        string       name;
        logic [12:0] exp;
    } sb_t;

    logic clk = 1'b0;
    logic rst;
    logic [4:0] rsD, rtD, rsE, rtE, writeregE, writeregM, writeregW;
    logic regwriteE, regwriteM, regwriteW, memtoregE, memtoregM;
    logic branchD, pcsrcD, jumpD, divstartE;
    logic stallF, stallD, stallE, flushD, flushE, forwardAD, forwardBD;
    logic [1:0] forwardAE, forwardBE;
    logic div_busy, div_ready;
    logic [12:0] act;

    int unsigned n_vec = 0;
    int unsigned n_bad = 0;
    sb_t  sb[$];
    vec_t tbl[16];

    always #5 clk = ~clk;

    pipe_hazard_ctrl #(.DIV_CYCLES(DIVC)) dut (
        .clk(clk), .rst(rst),
        .rsD(rsD), .rtD(rtD), .rsE(rsE), .rtE(rtE),
        .writeregE(writeregE), .writeregM(writeregM), .writeregW(writeregW),
        .regwriteE(regwriteE), .regwriteM(regwriteM), .regwriteW(regwriteW),
        .memtoregE(memtoregE), .memtoregM(memtoregM),
        .branchD(branchD), .pcsrcD(pcsrcD), .jumpD(jumpD), .divstartE(divstartE),
        .stallF(stallF), .stallD(stallD), .stallE(stallE),
        .flushD(flushD), .flushE(flushE),
        .forwardAD(forwardAD), .forwardBD(forwardBD),
        .forwardAE(forwardAE), .forwardBE(forwardBE),
        .div_busy(div_busy), .div_ready(div_ready)
    );

    assign act = {stallF, stallD, stallE, flushD, flushE, forwardAD, forwardBD,
                  forwardAE, forwardBE, div_busy, div_ready};

    function automatic in_t mk(input logic [4:0] a, input logic [4:0] b, input logic [4:0] c,
                               input logic [4:0] d, input logic [4:0] e, input logic [4:0] m,
                               input logic [4:0] w, input logic [9:0] ctl);
        in_t r;
        r.rsD = a; r.rtD = b; r.rsE = c; r.rtE = d;
        r.wE = e;  r.wM = m;  r.wW = w;  r.ctl = ctl;
        return r;
    endfunction

    task automatic drive(input in_t v);
        rsD = v.rsD; rtD = v.rtD; rsE = v.rsE; rtE = v.rtE;
        writeregE = v.wE; writeregM = v.wM; writeregW = v.wW;
        {rst, regwriteE, regwriteM, regwriteW, memtoregE, memtoregM,
         branchD, pcsrcD, jumpD, divstartE} = v.ctl;
    endtask

    task automatic check();
        sb_t e;
        n_vec++;
        if (sb.size() == 0) begin
            n_bad++;
            $display("FAIL scoreboard_empty: output %b with no expected entry", act);
        end else begin
            e = sb.pop_front();
            if (act !== e.exp) begin
                n_bad++;
                $display("FAIL %s: got %b expected %b", e.name, act, e.exp);
            end
        end
    endtask

    // Called just after a rising edge; drives, then samples on the falling edge.
    task automatic step(input string name, input in_t v, input logic [12:0] exp);
        drive(v);
        sb.push_back('{name, exp});
        @(negedge clk);
        check();
        @(posedge clk);
        #1;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached, expected $finish");
        $fatal(1);
    end

    initial begin
        tbl[0]  = '{"idle_zero",      mk(0,0,0,0,0,0,0, 10'd0),             E_ZERO};
        tbl[1]  = '{"loaduse_rs",     mk(8,0,0,0,8,0,0, MTE|RWE),           E_HAZ};
        tbl[2]  = '{"loaduse_rt",     mk(0,8,0,0,8,0,0, MTE|RWE),           E_HAZ};
        tbl[3]  = '{"load_r0",        mk(0,0,0,0,0,0,0, MTE|RWE),           E_ZERO};
        tbl[4]  = '{"fwdAE_M_prio",   mk(0,0,5,0,0,5,5, RWM|RWW),           13'b00000_00_10_00_00};
        tbl[5]  = '{"fwdAE_W",        mk(0,0,5,0,0,5,5, RWW),               13'b00000_00_01_00_00};
        tbl[6]  = '{"fwdAE_r0",       mk(0,0,0,0,0,0,0, RWW),               E_ZERO};
        tbl[7]  = '{"fwdE_mixed",     mk(0,0,9,7,0,7,9, RWM|RWW),           13'b00000_00_01_10_00};
        tbl[8]  = '{"fwdD_both",      mk(4,4,0,0,0,4,0, RWM),               13'b00000_11_00_00_00};
        tbl[9]  = '{"fwdD_r0",        mk(0,0,0,0,0,0,0, RWM),               E_ZERO};
        tbl[10] = '{"branch_hazE",    mk(3,0,0,0,3,0,0, BR|PC|RWE),         E_HAZ};
        tbl[11] = '{"branch_taken",   mk(3,0,0,0,0,0,0, BR|PC|RWE),         E_FD};
        tbl[12] = '{"branch_hazM",    mk(0,6,0,0,0,6,0, BR|MTM|RWM),        13'b11001_01_00_00_00};
        tbl[13] = '{"branch_nowr",    mk(3,0,0,0,3,0,0, BR),                E_ZERO};
        tbl[14] = '{"jump",           mk(0,0,0,0,0,0,0, JMP),               E_FD};
        tbl[15] = '{"jump_loaduse",   mk(8,0,0,0,8,0,0, JMP|MTE|RWE),       E_HAZ};

        drive(mk(0,0,0,0,0,0,0, RST));
        @(posedge clk);
        #1;
        step("reset_hold", mk(0,0,0,0,0,0,0, RST), E_ZERO);
        step("after_reset", mk(0,0,0,0,0,0,0, 10'd0), E_ZERO);

        for (int i = 0; i < 16; i++) step(tbl[i].name, tbl[i].in, tbl[i].exp);
        step("loaduse_released", mk(8,0,0,0,0,0,0, 10'd0), E_ZERO);

        // Divide: stalls for DIVC-1 cycles, one ready pulse; load-use inside is not flushed.
        step("div_c0", mk(0,0,0,0,0,0,0, DIV), E_DIV);
        step("div_c1_lw", mk(8,0,0,0,8,0,0, DIV|MTE|RWE), E_DIV);
        step("div_c2", mk(0,0,0,0,0,0,0, DIV), E_DIV);
        step("div_c3_done", mk(0,0,0,0,0,0,0, DIV), E_DONE);
        step("div_next_idle", mk(0,0,0,0,0,0,0, 10'd0), E_ZERO);

        // Back-to-back: divstartE still high after DONE starts a new divide.
        for (int i = 0; i < 3; i++) step("b2b_first", mk(0,0,0,0,0,0,0, DIV), E_DIV);
        step("b2b_done1", mk(0,0,0,0,0,0,0, DIV), E_DONE);
        for (int i = 0; i < 3; i++) step("b2b_second", mk(0,0,0,0,0,0,0, DIV), E_DIV);
        step("b2b_done2", mk(0,0,0,0,0,0,0, 10'd0), E_DONE);
        step("b2b_idle", mk(0,0,0,0,0,0,0, 10'd0), E_ZERO);

        // Reset during RUN: stalls persist in the reset cycle, drop after, no ready pulse.
        step("rst_div_c0", mk(0,0,0,0,0,0,0, DIV), E_DIV);
        step("rst_div_c1", mk(0,0,0,0,0,0,0, DIV|RST), E_DIV);
        step("rst_div_after", mk(0,0,0,0,0,0,0, 10'd0), E_ZERO);
        step("rst_div_noready", mk(0,0,0,0,0,0,0, 10'd0), E_ZERO);

        // Jump held through a divide: flushD suppressed until the stall releases.
        for (int i = 0; i < 3; i++) step("jmp_div_run", mk(0,0,0,0,0,0,0, DIV|JMP), E_DIV);
        step("jmp_div_done", mk(0,0,0,0,0,0,0, DIV|JMP), 13'b00010_00_00_00_01);
        step("jmp_div_idle", mk(0,0,0,0,0,0,0, JMP), E_FD);
        step("final_idle", mk(0,0,0,0,0,0,0, 10'd0), E_ZERO);

        if (sb.size() != 0) begin
            n_bad++;
            $display("FAIL scoreboard_leftover: %0d entries remain, expected 0", sb.size());
        end
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule

// File: doc/pipe_hazard_ctrl.md
Name: pipe_hazard_ctrl

Overview:
Hazard and pipeline-control unit for the 5-stage MIPS core. It produces the stall (enable) and flush (clear) signals that drive the F/D/E pipeline registers, and the forwarding selects for the D and E stages. It also sequences a multi-cycle divider: a cycle counter holds the front of the pipe until the divide completes. This block is the producer side of every pipeline-register clear in the datapath.

Parameters:
DIV_CYCLES, 32, number of cycles the divider occupies the E stage (minimum 2).
CW, $clog2(DIV_CYCLES), width of the divide cycle counter.

Ports:
clk  in  1  clock, all state changes on rising edge
rst  in  1  synchronous active-high reset
rsD  in  5  source reg rs in D
rtD  in  5  source reg rt in D
rsE  in  5  source reg rs in E
rtE  in  5  source reg rt in E
writeregE  in  5  destination reg in E
writeregM  in  5  destination reg in M
writeregW  in  5  destination reg in W
regwriteE  in  1  E writes the register file
regwriteM  in  1  M writes the register file
regwriteW  in  1  W writes the register file
memtoregE  in  1  E is a load
memtoregM  in  1  M is a load
branchD  in  1  D is a branch
pcsrcD  in  1  branch in D is taken
jumpD  in  1  D is a jump
divstartE  in  1  divide instruction present in E
stallF  out  1  hold PC
stallD  out  1  hold F/D register
stallE  out  1  hold D/E register
flushD  out  1  clear F/D register
flushE  out  1  clear D/E register
forwardAD  out  1  forward M ALU result to rs in D
forwardBD  out  1  forward M ALU result to rt in D
forwardAE  out  2  rs select in E: 00 regfile, 10 M, 01 W
forwardBE  out  2  rt select in E, same encoding
div_busy  out  1  divider sequence in progress
div_ready  out  1  one-cycle pulse, divide result valid

Behaviour:
- Reset: clk and rst only; rst is sampled on the rising edge and is synchronous, active-high. The edge with rst=1 sets state IDLE and counter 0. While in IDLE with no hazard, all outputs are 0.
- Register 0 never matches in any comparison.
- Forwarding is combinational.
  - forwardAE = 10 if regwriteM and writeregM==rsE; otherwise 01 if regwriteW and writeregW==rsE; otherwise 00. M has priority over W. forwardBE is the same using rtE.
  - forwardAD = regwriteM and writeregM==rsD. forwardBD is the same using rtD.
- lwstall = memtoregE and (writeregE==rsD or writeregE==rtD).
- branchstall = branchD and ((regwriteE and writeregE matches rsD or rtD) or (memtoregM and writeregM matches rsD or rtD)).
- divstall = (state==IDLE and divstartE) or state==RUN.
- Stall and flush outputs:
  - stallF = stallD = lwstall or branchstall or divstall.
  - stallE = divstall.
  - flushE = (lwstall or branchstall) and not divstall. The E stage holds during a divide and is never cleared.
  - flushD = (pcsrcD or jumpD) and not stallD.
- FSM (states IDLE, RUN, DONE):
  - IDLE: on divstartE, load counter with DIV_CYCLES-2 and go to RUN.
  - RUN: decrement the counter each cycle. At counter==0, go to DONE.
  - DONE: div_ready=1, stalls released for this cycle, return to IDLE.
  - div_busy = 1 in RUN, and in IDLE when divstartE=1.
  - Total stall is DIV_CYCLES-1 cycles. The result is consumed in the DONE cycle, so the divide occupies E for DIV_CYCLES cycles.
- Back-to-back divides: divstartE is ignored in DONE. E advances in DONE, so a following divide is seen in the next IDLE cycle.
- Reset mid-divide: the next edge returns to IDLE. div_ready does not pulse and the stalls drop after that edge.
- A branch resolving in D while the divider is in RUN: stallD suppresses flushD. The flush occurs once the stall releases.

Test Plan:
- Load-use: lw $8 in E (memtoregE=1, writeregE=8), rsD=8 -> stallF=stallD=1 and flushE=1 for exactly one cycle, then all 0.
- Forwarding priority: regwriteM=1, writeregM=5; regwriteW=1, writeregW=5; rsE=5 -> forwardAE=10. Drop regwriteM -> 01. Set writeregW=0, rsE=0 -> 00.
- Branch hazard: branchD=1, rsD=3, regwriteE=1, writeregE=3 -> stallD=1, flushE=1, flushD=0 despite pcsrcD=1. Next cycle with the hazard gone and pcsrcD=1 -> flushD=1.
- Divide, DIV_CYCLES=4: divstartE pulses at cycle 0 -> stallF/D/E=1 for cycles 0-2, div_ready=1 at cycle 3 only, flushE=0 throughout.
- Reset mid-divide: assert rst in the cycle-1 RUN cycle -> IDLE after that edge, div_busy=0, no div_ready pulse.
- Jump during divide: jumpD=1 held while in RUN -> flushD=0 until the DONE cycle, then flushD=1.
